// File: rtl/pipeline_dbg_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_dbg_ctrl: UART-fed program loader and run/step controller for   |
// | the MIPS pipeline. Optional single-step support: define STEP_MODE_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_dbg_ctrl #(
   parameter int NB_DATA    = 32,
   parameter int NB_IADDR   = 32,
   parameter int MAX_WORDS  = 256,
   parameter int RST_CYCLES = 2
) (
   input  logic                clk,
   input  logic                i_rst,
   input  logic [7:0]          i_rx_data,
   input  logic                i_rx_valid,
   input  logic                i_pipe_end,
   output logic                o_we_IF,
   output logic [NB_DATA-1:0]  o_instruction_data,
   output logic [NB_IADDR-1:0] o_inst_addr,
   output logic                o_halt,
   output logic                o_pipe_rst_n,
   output logic [2:0]          o_state,
   output logic [31:0]         o_cycle_count,
   output logic                o_done,
   output logic                o_error
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_PIPE_RST = 3'd2;
   localparam logic [2:0] S_RUN      = 3'd3;
   localparam logic [2:0] S_STEP     = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam int NB_BYTES = NB_DATA / 8;
   localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
   localparam int NB_WCNT  = $clog2(MAX_WORDS + 1);
   localparam int NB_RCNT  = $clog2(RST_CYCLES + 1);

   logic [2:0]          state_q, state_d;
   logic                we_q, we_d;
   logic [NB_DATA-1:0]  data_q, data_d;
   logic [NB_IADDR-1:0] iaddr_q, iaddr_d;
   logic                halt_q, halt_d;
   logic                prst_n_q, prst_n_d;
   logic [31:0]         cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [NB_DATA-1:0]  shift_q, shift_d;
   logic [NB_BCNT-1:0]  bcnt_q, bcnt_d;
   logic [NB_IADDR-1:0] addr_q, addr_d;
   logic [NB_WCNT-1:0]  wcnt_q, wcnt_d;
   logic [NB_RCNT-1:0]  rcnt_q, rcnt_d;

   always_comb begin
      state_d  = state_q;
      we_d     = 1'b0;
      data_d   = data_q;
      iaddr_d  = iaddr_q;
      halt_d   = 1'b1;
      prst_n_d = 1'b1;
      done_d   = 1'b0;
      err_d    = err_q;
      shift_d  = shift_q;
      bcnt_d   = bcnt_q;
      addr_d   = addr_q;
      wcnt_d   = wcnt_q;
      rcnt_d   = rcnt_q;
      // Counts cycles the pipeline actually advanced (halt low), saturating.
      cnt_d    = (!halt_q && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;

      case (state_q)
         S_IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  8'h4C: begin
                     state_d = S_LOAD;
                     addr_d  = '0;
                     bcnt_d  = '0;
                     wcnt_d  = '0;
                  end
                  8'h43: begin
                     state_d = S_RUN;
                     halt_d  = 1'b0;
                  end
`ifdef STEP_MODE_EN
                  8'h53: state_d = S_STEP;
`endif
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_LOAD: begin
            if (i_rx_valid) begin
               shift_d = {shift_q[NB_DATA-9:0], i_rx_data};
               bcnt_d  = bcnt_q + NB_BCNT'(1);
               if (bcnt_q == NB_BCNT'(NB_BYTES - 1)) begin
                  bcnt_d  = '0;
                  we_d    = 1'b1;
                  data_d  = shift_d;
                  iaddr_d = addr_q;
                  addr_d  = addr_q + NB_IADDR'(4);
                  wcnt_d  = wcnt_q + NB_WCNT'(1);
                  if (shift_d[NB_DATA-1 -: 6] == 6'b111111) begin
                     state_d  = S_PIPE_RST;
                     prst_n_d = 1'b0;
                     rcnt_d   = '0;
                  end else if (wcnt_q == NB_WCNT'(MAX_WORDS - 1)) begin
                     err_d    = 1'b1;
                     state_d  = S_PIPE_RST;
                     prst_n_d = 1'b0;
                     rcnt_d   = '0;
                  end
               end
            end
         end
         S_PIPE_RST: begin
            cnt_d = '0;
            if (rcnt_q == NB_RCNT'(RST_CYCLES - 1)) begin
               state_d = S_IDLE;
            end else begin
               rcnt_d   = rcnt_q + NB_RCNT'(1);
               prst_n_d = 1'b0;
            end
         end
         S_RUN: begin
            if (i_pipe_end) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               halt_d = 1'b0;
            end
         end
`ifdef STEP_MODE_EN
         S_STEP: begin
            // End of program takes priority over a coincident step request.
            if (i_pipe_end) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (i_rx_valid && i_rx_data == 8'h53) begin
               halt_d = 1'b0;
            end else if (i_rx_valid && i_rx_data == 8'h43) begin
               state_d = S_RUN;
               halt_d  = 1'b0;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         data_q   <= '0;
         iaddr_q  <= '0;
         halt_q   <= 1'b1;
         prst_n_q <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         shift_q  <= '0;
         bcnt_q   <= '0;
         addr_q   <= '0;
         wcnt_q   <= '0;
         rcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         data_q   <= data_d;
         iaddr_q  <= iaddr_d;
         halt_q   <= halt_d;
         prst_n_q <= prst_n_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         shift_q  <= shift_d;
         bcnt_q   <= bcnt_d;
         addr_q   <= addr_d;
         wcnt_q   <= wcnt_d;
         rcnt_q   <= rcnt_d;
      end
   end

   assign o_we_IF            = we_q;
   assign o_instruction_data = data_q;
   assign o_inst_addr        = iaddr_q;
   assign o_halt             = halt_q;
   assign o_pipe_rst_n       = prst_n_q;
   assign o_state            = state_q;
   assign o_cycle_count      = cnt_q;
   assign o_done             = done_q;
   assign o_error            = err_q;

endmodule
`default_nettype wire
